// File: rtl/if_id_queue_if.sv
// Valid/ready channel carrying one instruction and its PC between pipeline stages.
// The master drives valid/ins/pc; the slave answers with ready.
interface if_id_queue_if #(
  parameter int unsigned INS_W = 32,
  parameter int unsigned PC_W  = 32
);
  logic             valid;
  logic             ready;
  logic [INS_W-1:0] ins;
  logic [PC_W-1:0]  pc;

  modport master (output valid, ins, pc, input ready);
  modport slave  (input valid, ins, pc, output ready);
endinterface

// File: rtl/if_id_queue.sv
// DEPTH-entry FIFO of {instruction, PC} between fetch and decode, with flush
// and a sticky halt that injects HALT_INS and then stops accepting fetches.
module if_id_queue #(
  parameter int unsigned      INS_W    = 32,
  parameter int unsigned      PC_W     = 32,
  parameter int unsigned      DEPTH    = 2,
  parameter logic [INS_W-1:0] NOP_INS  = '0,
  parameter logic [INS_W-1:0] HALT_INS = INS_W'(32'h0000000c)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         halt,
  if_id_queue_if.slave                 fetch,
  if_id_queue_if.master                dec,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         halted
);

  localparam int unsigned      CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned      PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

  typedef enum logic {RUN, HALTED} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;

  logic [INS_W-1:0] ins_mem [DEPTH];
  logic [PC_W-1:0]  pc_mem  [DEPTH];

  logic             in_ready, out_valid, push, pop;
  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;
  logic [INS_W-1:0] wr_ins;

  // Wrap at DEPTH-1 explicitly so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    in_ready  = (state_q == RUN) && (count_q < DEPTH_C);
    out_valid = (count_q != '0);
    push      = fetch.valid && in_ready;
    pop       = out_valid && dec.ready;

    state_d = state_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    wr_en   = 1'b0;
    wr_addr = tail_q;
    wr_ins  = fetch.ins;

    if (flush) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else if (halt && (state_q == RUN)) begin
      // Queue restarts from slot 0 holding only the halt entry.
      state_d = HALTED;
      count_d = CNT_W'(1);
      head_d  = '0;
      tail_d  = ptr_inc('0);
      wr_en   = 1'b1;
      wr_addr = '0;
      wr_ins  = HALT_INS;
    end else begin
      if (push) begin
        wr_en  = 1'b1;
        tail_d = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      ins_mem[wr_addr] <= wr_ins;
      pc_mem[wr_addr]  <= fetch.pc;
    end
  end

  assign fetch.ready = in_ready;
  assign dec.valid   = out_valid;
  assign dec.ins     = out_valid ? ins_mem[head_q] : NOP_INS;
  assign dec.pc      = out_valid ? pc_mem[head_q] : '0;
  assign count       = count_q;
  assign halted      = (state_q == HALTED);

endmodule
